// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for LANES fetch slots: load, bubble, hold and flush under the global
// stall vector, with NOP substitution on empty lanes, a saturating bubble counter and a hold watchdog.
module if_id_stage_reg #(
    parameter int                LANES    = 1,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                STALL_W  = 6,
    parameter int                STAGE    = 1,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16,
    parameter int                TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES*ADDR_W-1:0]   if_pc,
    input  logic [LANES*INST_W-1:0]   if_inst,
    input  logic [LANES-1:0]          if_valid,
    output logic [LANES*ADDR_W-1:0]   id_pc,
    output logic [LANES*INST_W-1:0]   id_inst,
    output logic [LANES-1:0]          id_valid,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic                      stall_timeout
);

    localparam int                HOLD_W   = $clog2(TIMEOUT + 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {
        OP_RESET,
        OP_FLUSH,
        OP_BUBBLE,
        OP_LOAD,
        OP_HOLD
    } op_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    op_t                      op;
    logic                     stall_here;
    logic                     stall_next;
    logic [LANES*ADDR_W-1:0]  pc_p1;
    logic [LANES*INST_W-1:0]  inst_p1;
    logic [LANES-1:0]         vld_p1;
    logic [CNT_W-1:0]         bubble_cnt_p1;
    logic [HOLD_W-1:0]        hold_cnt_p1;
    logic                     timeout_p1;
    logic                     unused_stall_bits;

    assign stall_here        = stall[STAGE];
    assign stall_next        = stall[STAGE+1];
    assign unused_stall_bits = ^stall;

    // First matching condition wins; flush outranks every stall combination.
    always_comb begin
        op = OP_HOLD;
        if (rst)
            op = OP_RESET;
        else if (flush)
            op = OP_FLUSH;
        else if (stall_here && !stall_next)
            op = OP_BUBBLE;
        else if (!stall_here)
            op = OP_LOAD;
        else
            op = OP_HOLD;
    end

    // ---- IF -> ID boundary ----
    always_ff @(posedge clk) begin
        unique case (op)
            OP_RESET, OP_FLUSH, OP_BUBBLE: begin
                pc_p1   <= '0;
                inst_p1 <= {LANES{NOP_INST}};
                vld_p1  <= '0;
            end
            OP_LOAD: begin
                for (int i = 0; i < LANES; i++) begin
                    if (if_valid[i]) begin
                        pc_p1[i*ADDR_W +: ADDR_W]   <= if_pc[i*ADDR_W +: ADDR_W];
                        inst_p1[i*INST_W +: INST_W] <= if_inst[i*INST_W +: INST_W];
                    end else begin
                        pc_p1[i*ADDR_W +: ADDR_W]   <= '0;
                        inst_p1[i*INST_W +: INST_W] <= NOP_INST;
                    end
                end
                vld_p1 <= if_valid;
            end
            default: begin
                pc_p1   <= pc_p1;
                inst_p1 <= inst_p1;
                vld_p1  <= vld_p1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (op == OP_RESET)
            bubble_cnt_p1 <= '0;
        else if (op == OP_BUBBLE)
            bubble_cnt_p1 <= sat_inc_cnt(bubble_cnt_p1);

        // Watchdog fires on the edge after the count has passed TIMEOUT.
        if (op == OP_HOLD) begin
            hold_cnt_p1 <= sat_inc_hold(hold_cnt_p1);
            timeout_p1  <= (hold_cnt_p1 > HOLD_LIM);
        end else begin
            hold_cnt_p1 <= '0;
            timeout_p1  <= 1'b0;
        end
    end

    assign id_pc         = pc_p1;
    assign id_inst       = inst_p1;
    assign id_valid      = vld_p1;
    assign bubble_cnt    = bubble_cnt_p1;
    assign stall_timeout = timeout_p1;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: a per-edge vector table plus hand sequences for the
// hold watchdog, flush-during-hold and reset-during-hold cases.
module tb_if_id_stage_reg;

    localparam int          LANES   = 2;
    localparam int          ADDR_W  = 32;
    localparam int          INST_W  = 32;
    localparam int          STALL_W = 6;
    localparam int          STAGE   = 1;
    localparam int          CNT_W   = 2;
    localparam int          TIMEOUT = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [63:0] NOP2    = {NOP, NOP};
    localparam logic [5:0]  RUN     = 6'b000000;
    localparam logic [5:0]  BUB     = 6'b000010;
    localparam logic [5:0]  HLD     = 6'b000110;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES*ADDR_W-1:0] if_pc;
    logic [LANES*INST_W-1:0] if_inst;
    logic [LANES-1:0]        if_valid;
    logic [LANES*ADDR_W-1:0] id_pc;
    logic [LANES*INST_W-1:0] id_inst;
    logic [LANES-1:0]        id_valid;
    logic [CNT_W-1:0]        bubble_cnt;
    logic                    stall_timeout;

    if_id_stage_reg #(
        .LANES(LANES), .ADDR_W(ADDR_W), .INST_W(INST_W), .STALL_W(STALL_W), .STAGE(STAGE),
        .NOP_INST(NOP), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
        .bubble_cnt(bubble_cnt), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [63:0] pc;
        logic [63:0] inst;
        logic [1:0]  vld;
        logic [63:0] epc;
        logic [63:0] einst;
        logic [1:0]  evld;
        logic [1:0]  ecnt;
        logic        eto;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [63:0] epc, input logic [63:0] einst,
                             input logic [1:0] evld, input logic [1:0] ecnt, input logic eto);
        check({tag, " pc"},      id_pc,         epc);
        check({tag, " inst"},    id_inst,       einst);
        check({tag, " valid"},   id_valid,      64'(evld));
        check({tag, " cnt"},     bubble_cnt,    64'(ecnt));
        check({tag, " timeout"}, stall_timeout, 64'(eto));
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic f,
                         input logic [63:0] pc, input logic [63:0] inst, input logic [1:0] v);
        rst = r; stall = s; flush = f; if_pc = pc; if_inst = inst; if_valid = v;
    endtask

    initial begin
        logic [63:0] fpc;
        logic [63:0] finst;

        drive(1'b1, RUN, 1'b0, '0, '0, '0);

        // rst, stall, flush, if_pc, if_inst, if_valid | exp pc, inst, valid, cnt, timeout
        vq.push_back('{1'b1, RUN, 1'b0, 64'h00000104_00000100, 64'h24020007_24010005, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b1, RUN, 1'b0, 64'h00000104_00000100, 64'h24020007_24010005, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000104_00000100, 64'h24020007_24010005, 2'b11,
                       64'h00000104_00000100, 64'h24020007_24010005, 2'b11, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000204_00000200, 64'haaaaaaaa_bbbbbbbb, 2'b01,
                       64'h00000000_00000200, {NOP, 32'hbbbbbbbb}, 2'b01, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000304_00000300, 64'hcccccccc_dddddddd, 2'b10,
                       64'h00000304_00000000, {32'hcccccccc, NOP}, 2'b10, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000404_00000400, 64'h11111111_22222222, 2'b11,
                       64'h00000404_00000400, 64'h11111111_22222222, 2'b11, 2'd0, 1'b0});
        vq.push_back('{1'b0, HLD, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h00000404_00000400, 64'h11111111_22222222, 2'b11, 2'd0, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd1, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd2, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd3, 1'b0});
        vq.push_back('{1'b0, HLD, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd3, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd3, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd3, 1'b0});
        vq.push_back('{1'b1, BUB, 1'b0, 64'hdead0004_dead0000, 64'hbad00001_bad00002, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000504_00000500, 64'h33333333_44444444, 2'b11,
                       64'h00000504_00000500, 64'h33333333_44444444, 2'b11, 2'd0, 1'b0});
        vq.push_back('{1'b0, BUB, 1'b1, 64'h00000604_00000600, 64'h55555555_66666666, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000704_00000700, 64'h77777777_88888888, 2'b11,
                       64'h00000704_00000700, 64'h77777777_88888888, 2'b11, 2'd0, 1'b0});
        vq.push_back('{1'b0, HLD, 1'b1, 64'h00000804_00000800, 64'h99999999_aaaaaaaa, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b1, 64'h00000904_00000900, 64'hbbbbbbbb_cccccccc, 2'b11,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});
        vq.push_back('{1'b0, RUN, 1'b0, 64'h00000a04_00000a00, 64'hdddddddd_eeeeeeee, 2'b00,
                       64'h0, NOP2, 2'b00, 2'd0, 1'b0});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].stall, vq[i].flush, vq[i].pc, vq[i].inst, vq[i].vld);
            step();
            check_all($sformatf("vec%0d", i), vq[i].epc, vq[i].einst, vq[i].evld,
                      vq[i].ecnt, vq[i].eto);
        end

        // Watchdog: eight hold edges, timeout visible from the sixth.
        fpc   = 64'h00001004_00001000;
        finst = 64'h12345678_9abcdef0;
        drive(1'b0, RUN, 1'b0, fpc, finst, 2'b11);
        step();
        check_all("wd load", fpc, finst, 2'b11, 2'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, HLD, 1'b0, 64'(k), 64'(~k), 2'b11);
            step();
            check($sformatf("wd hold%0d timeout", k), stall_timeout, 64'(k >= 6));
            check($sformatf("wd hold%0d pc", k), id_pc, fpc);
        end
        drive(1'b0, RUN, 1'b0, 64'h00002004_00002000, 64'h0badf00d_0defaced, 2'b11);
        step();
        check_all("wd release", 64'h00002004_00002000, 64'h0badf00d_0defaced, 2'b11, 2'd0, 1'b0);

        // Flush during a long hold clears the watchdog and its counter.
        for (int k = 1; k <= 7; k++) begin
            drive(1'b0, HLD, 1'b0, '0, '0, 2'b11);
            step();
            check($sformatf("fh hold%0d timeout", k), stall_timeout, 64'(k >= 6));
        end
        drive(1'b0, HLD, 1'b1, 64'h00003004_00003000, 64'h1, 2'b11);
        step();
        check_all("fh flush", 64'h0, NOP2, 2'b00, 2'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, HLD, 1'b0, '0, '0, 2'b11);
            step();
            check($sformatf("fh rehold%0d timeout", k), stall_timeout, 64'(k >= 6));
        end

        // Reset while the watchdog is active.
        drive(1'b1, HLD, 1'b0, '0, '0, 2'b11);
        step();
        check_all("rh reset", 64'h0, NOP2, 2'b00, 2'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, HLD, 1'b0, '0, '0, 2'b11);
            step();
            check($sformatf("rh hold%0d timeout", k), stall_timeout, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
